// File: rtl/mult_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM state encoding and width helpers.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N   = 6;
  localparam int unsigned DEF_REQ = 4;
  localparam int unsigned PW      = 2 * DEF_N;

  // Product width for an n-bit operand pair.
  function automatic int unsigned pw_of(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/MultiplierNbitAnySize.sv
// Combinational unsigned N x N array multiplier producing a full 2N-bit product.
module MultiplierNbitAnySize #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_p_c
);

  localparam int unsigned PWL = 2 * WIDTH;

  logic [PWL-1:0] w_acc;

  // Accumulate one shifted partial-product row per multiplier bit.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_b[i]) begin
        w_acc = w_acc + (PWL'(i_a) << i);
      end
    end
  end

  assign o_p_c = w_acc;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping modulo REQ.
module rr_pick #(
  parameter int unsigned REQ = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [REQ-1:0] i_valid,
  input  logic [IDW-1:0] i_ptr,
  output logic [REQ-1:0] o_grant_c,
  output logic [IDW-1:0] o_idx_c,
  output logic           o_any_c
);

  logic [REQ-1:0] w_rot;
  int unsigned    w_sum;

  // Rotate a doubled copy so bit 0 is the ptr position, then find-first.
  always_comb begin
    w_rot   = REQ'({i_valid, i_valid} >> i_ptr);
    o_any_c = |w_rot;
    o_idx_c = '0;
    w_sum   = 0;
    for (int k = REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = 32'(i_ptr) + 32'(k);
        if (w_sum >= REQ) begin
          w_sum = w_sum - REQ;
        end
        o_idx_c = IDW'(w_sum);
      end
    end
    o_grant_c = '0;
    for (int k = 0; k < REQ; k++) begin
      o_grant_c[k] = o_any_c && (o_idx_c == IDW'(k));
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier array among REQ requesters;
// one operation in flight, result tagged with its requester id and held under backpressure.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned N   = DEF_N,
  parameter int unsigned REQ = DEF_REQ,
  parameter int unsigned IDW = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REQ-1:0]   req_valid,
  output logic [REQ-1:0]   req_ready,
  input  logic [REQ*N-1:0] req_m,
  input  logic [REQ*N-1:0] req_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_p,
  output logic [IDW-1:0]   res_id,
  output logic             busy
);

  localparam int unsigned PWT = pw_of(N);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   r_op_m;
  logic [N-1:0]   r_op_q;
  logic [PWT-1:0] r_res_p;
  logic [IDW-1:0] r_res_id;
  logic           r_res_valid;

  logic [REQ-1:0] w_grant;
  logic [IDW-1:0] w_idx;
  logic           w_any;
  logic [PWT-1:0] w_prod;
  logic           w_take;

  rr_pick #(
    .REQ (REQ),
    .IDW (IDW)
  ) u_pick (
    .i_valid   (req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  MultiplierNbitAnySize #(
    .WIDTH (N)
  ) u_mult (
    .i_a   (r_op_m),
    .i_b   (r_op_q),
    .o_p_c (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_DONE;
      S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_take = (r_state == S_IDLE) && w_any && !rst;

  // Operand capture, pointer advance and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_op_m      <= '0;
      r_op_q      <= '0;
      r_res_p     <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_op_m   <= req_m[w_idx*N +: N];
        r_op_q   <= req_q[w_idx*N +: N];
        r_res_id <= w_idx;
        r_ptr    <= (w_idx == IDW'(REQ - 1)) ? '0 : IDW'(w_idx + IDW'(1));
      end
      if (r_state == S_CALC) begin
        r_res_p     <= w_prod;
        r_res_valid <= 1'b1;
      end else if ((r_state == S_DONE) && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_take ? w_grant : '0;
  assign res_valid = r_res_valid;
  assign res_p     = r_res_p;
  assign res_id    = r_res_id;
  assign busy      = (r_state == S_CALC) || (r_state == S_DONE);

endmodule
